alu_op_sequencer: RTL

//  Control FSM between the instruction link and the ALU. It accepts one 11-bit word
//  {num1[10:7], num2[6:3], oper[2:1], Ain[0]} per handshake and registers the operands.
//  It issues the operation to the ALU, waits a fixed ALU latency and captures result and

---
 rtl/alu_op_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one instruction word per handshake, launches the ALU,
// waits a fixed ALU latency, captures result/flags and holds them valid for display.
// A word with Ain=1 makes the next accepted word take the last captured result as num1.
module alu_op_sequencer #(
    parameter int ALU_LAT     = 1,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [10:0] instruct,
    output logic        instr_ready,
    output logic [3:0]  alu_num1,
    output logic [3:0]  alu_num2,
    output logic [1:0]  alu_oper,
    output logic        alu_start,
    input  logic [3:0]  alu_result,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  res_out,
    output logic [3:0]  flags_out,
    output logic        res_valid,
    output logic        chain_active,
    output logic [1:0]  state_dbg
);

    // The counter only ever holds values up to max(ALU_LAT, HOLD_CYCLES) - 1.
    localparam int MAX_CNT = (ALU_LAT > HOLD_CYCLES) ? ALU_LAT : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    // Encoding is visible on state_dbg, so it is fixed explicitly.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             accept;
    logic             capture;

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next-state, counter update and the accept/capture strobes for the datapath.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    accept    = 1'b1;
                    count_nxt = LAT_LOAD;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (count == '0) begin
                    capture   = 1'b1;
                    count_nxt = HOLD_LOAD;
                    state_nxt = S_DONE;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            S_DONE: begin
                if (count == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand registers load only on acceptance; result registers only on capture.
    // Chaining reads res_out before this edge, i.e. the last completed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_num1     <= '0;
            alu_num2     <= '0;
            alu_oper     <= '0;
            chain_active <= 1'b0;
            res_out      <= '0;
            flags_out    <= '0;
        end else begin
            if (accept) begin
                alu_num1     <= chain_active ? res_out : instruct[10:7];
                alu_num2     <= instruct[6:3];
                alu_oper     <= instruct[2:1];
                chain_active <= instruct[0];
            end
            if (capture) begin
                res_out   <= alu_result;
                flags_out <= alu_flags;
            end
        end
    end

    // Status outputs decode directly from state, so start and valid can never overlap.
    always_comb begin
        instr_ready = (state == S_IDLE);
        alu_start   = (state == S_ISSUE);
        res_valid   = (state == S_DONE);
        state_dbg   = state;
    end

endmodule
